// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory bus between the core's instruction-fetch port
// and its data port. The winning request is forwarded downstream, its port ID
// is pushed into an in-order ID FIFO, and each downstream response (mem_valid)
// is routed back to whichever port sits at the head of that FIFO.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   instr_req/addr/gnt         instruction read request, accepted by instr_gnt
//   instr_rdata/valid/err      instruction response (rdata is 0 unless valid)
//   data_req/wr/addr/wdata/byteen, data_gnt   data request, accepted by data_gnt
//   data_rdata/valid           data response for reads and writes
//   mem_req/wr/addr/wdata/byteen, mem_gnt     downstream request channel
//   mem_rdata/valid/err        downstream response channel, in grant order
//   orphan_resp                sticky: a response arrived with nothing outstanding
//
// Handshake: a request is transferred in any cycle where mem_req and mem_gnt
// are both 1; the matching instr_gnt/data_gnt pulses in that same cycle.
// Requesters hold req and their fields stable until their gnt. A response is
// a single-cycle mem_valid pulse, strictly in grant order, never in the same
// cycle as its own grant.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                reset,
  // instruction port
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic                instr_gnt,
  output logic [DATA_W-1:0]   instr_rdata,
  output logic                instr_valid,
  output logic                instr_err,
  // data port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_byteen,
  output logic                data_gnt,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  // downstream memory bus
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byteen,
  input  logic                mem_gnt,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid,
  input  logic                mem_err,
  // status
  output logic                orphan_resp
);

  localparam int BE_W  = DATA_W / 8;
  // A single-entry FIFO still needs a 1-bit pointer to keep the vectors legal.
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

  // Arbitration state: OPEN re-selects every cycle, LOCKED holds the port
  // that was offered downstream but not yet accepted.
  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t           arb_state_q;
  logic                 lock_data_q;   // port held while LOCKED (1 = data)
  logic                 rr_data_q;     // round-robin tie winner (1 = data)
  logic [CNT_W-1:0]     count_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [MAX_OUTST-1:0] id_fifo_q;     // one ID bit per slot (1 = data)
  logic                 orphan_q;

  logic eligible;
  logic any_req;
  logic sel_data;
  logic req_out;
  logic push;
  logic pop;
  logic head_data;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Eligibility looks only at the registered count: a response popping in
  // this cycle does not open a slot until the next cycle.
  assign eligible = (count_q < CNT_MAX);
  assign any_req  = instr_req | data_req;

  always_comb begin
    sel_data = 1'b0;
    if (arb_state_q == ARB_LOCKED) begin
      sel_data = lock_data_q;
    end else if (DATA_PRIO != 0) begin
      sel_data = data_req;
    end else if (instr_req && data_req) begin
      sel_data = rr_data_q;
    end else begin
      sel_data = data_req;
    end
  end

  assign req_out = !reset && eligible && any_req;
  assign push    = req_out && mem_gnt;

  // Request fields are zero whenever no request is offered.
  always_comb begin
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    if (req_out) begin
      if (sel_data) begin
        mem_wr     = data_wr;
        mem_addr   = data_addr;
        mem_wdata  = data_wdata;
        mem_byteen = data_byteen;
      end else begin
        mem_addr   = instr_addr;
        mem_byteen = {BE_W{1'b1}};
      end
    end
  end

  assign mem_req   = req_out;
  assign instr_gnt = push && !sel_data;
  assign data_gnt  = push && sel_data;

  // ---------------------------------------------------------------------------
  // Response side: zero-latency route based on the FIFO head
  // ---------------------------------------------------------------------------
  assign pop       = !reset && mem_valid && (count_q != '0);
  assign head_data = id_fifo_q[rd_ptr_q];

  assign instr_valid = pop && !head_data;
  assign data_valid  = pop && head_data;
  assign instr_rdata = instr_valid ? mem_rdata : '0;
  assign data_rdata  = data_valid  ? mem_rdata : '0;
  assign instr_err   = instr_valid && mem_err;
  assign orphan_resp = orphan_q;

  // ---------------------------------------------------------------------------
  // ID storage: contents are only meaningful between push and pop, so the
  // slots themselves need no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo_q[wr_ptr_q] <= sel_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter state, FIFO pointers, count and orphan flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state_q <= ARB_OPEN;
      lock_data_q <= 1'b0;
      rr_data_q   <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      orphan_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q  <= ptr_next(wr_ptr_q);
        // The port just served loses the next tie.
        rr_data_q <= !sel_data;
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // Lock whenever a request is on the bus but not taken; a request that
      // disappears (ineligible or withdrawn) also drops the lock.
      if (req_out && !mem_gnt) begin
        arb_state_q <= ARB_LOCKED;
        lock_data_q <= sel_data;
      end else begin
        arb_state_q <= ARB_OPEN;
      end

      if (mem_valid && (count_q == '0)) begin
        orphan_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances: index 0 uses fixed data priority, index 1 uses
// round-robin. Each has its own stimulus signals. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // per-instance signals
  logic          instr_req   [2];
  logic [AW-1:0] instr_addr  [2];
  logic          instr_gnt   [2];
  logic [DW-1:0] instr_rdata [2];
  logic          instr_valid [2];
  logic          instr_err   [2];
  logic          data_req    [2];
  logic          data_wr     [2];
  logic [AW-1:0] data_addr   [2];
  logic [DW-1:0] data_wdata  [2];
  logic [BW-1:0] data_byteen [2];
  logic          data_gnt    [2];
  logic [DW-1:0] data_rdata  [2];
  logic          data_valid  [2];
  logic          mem_req     [2];
  logic          mem_wr      [2];
  logic [AW-1:0] mem_addr    [2];
  logic [DW-1:0] mem_wdata   [2];
  logic [BW-1:0] mem_byteen  [2];
  logic          mem_gnt     [2];
  logic [DW-1:0] mem_rdata   [2];
  logic          mem_valid   [2];
  logic          mem_err     [2];
  logic          orphan_resp [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_OUTST(MO),
      .DATA_PRIO((g == 0) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .instr_req  (instr_req[g]),
      .instr_addr (instr_addr[g]),
      .instr_gnt  (instr_gnt[g]),
      .instr_rdata(instr_rdata[g]),
      .instr_valid(instr_valid[g]),
      .instr_err  (instr_err[g]),
      .data_req   (data_req[g]),
      .data_wr    (data_wr[g]),
      .data_addr  (data_addr[g]),
      .data_wdata (data_wdata[g]),
      .data_byteen(data_byteen[g]),
      .data_gnt   (data_gnt[g]),
      .data_rdata (data_rdata[g]),
      .data_valid (data_valid[g]),
      .mem_req    (mem_req[g]),
      .mem_wr     (mem_wr[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_byteen (mem_byteen[g]),
      .mem_gnt    (mem_gnt[g]),
      .mem_rdata  (mem_rdata[g]),
      .mem_valid  (mem_valid[g]),
      .mem_err    (mem_err[g]),
      .orphan_resp(orphan_resp[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_all();
    for (int g = 0; g < 2; g++) begin
      instr_req[g]   = 1'b0;
      instr_addr[g]  = '0;
      data_req[g]    = 1'b0;
      data_wr[g]     = 1'b0;
      data_addr[g]   = '0;
      data_wdata[g]  = '0;
      data_byteen[g] = '0;
      mem_gnt[g]     = 1'b0;
      mem_rdata[g]   = '0;
      mem_valid[g]   = 1'b0;
      mem_err[g]     = 1'b0;
    end
  endtask

  // Leaves the caller on a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: outstanding IDs in a queue, plus lock / tie / orphan flags
  // ---------------------------------------------------------------------------
  bit m_q[$];        // IDs in grant order (1 = data)
  bit m_locked;
  bit m_lock_data;
  bit m_pref_data;   // port that wins the next round-robin tie
  bit m_orphan;

  task automatic model_reset();
    m_q.delete();
    m_locked    = 1'b0;
    m_lock_data = 1'b0;
    m_pref_data = 1'b0;
    m_orphan    = 1'b0;
  endtask

  // Compares instance p against the model for the current cycle, then
  // advances the model across the coming rising edge.
  task automatic model_cycle(input int p, output bit e_igt, output bit e_dgt);
    bit ereq, sel_d, push, pop, head, e_iv, e_dv;
    int sz;
    sz   = m_q.size();
    ereq = (sz < MO) && (instr_req[p] || data_req[p]);
    if (m_locked)                           sel_d = m_lock_data;
    else if (p == 0)                        sel_d = data_req[p];
    else if (instr_req[p] && data_req[p])   sel_d = m_pref_data;
    else                                    sel_d = data_req[p];
    push  = ereq && mem_gnt[p];
    e_igt = push && !sel_d;
    e_dgt = push && sel_d;
    pop   = mem_valid[p] && (sz > 0);
    head  = pop ? m_q[0] : 1'b0;
    e_iv  = pop && !head;
    e_dv  = pop && head;

    chk("rnd_mem_req", mem_req[p], ereq);
    chk("rnd_instr_gnt", instr_gnt[p], e_igt);
    chk("rnd_data_gnt", data_gnt[p], e_dgt);
    if (ereq) begin
      chk("rnd_mem_addr", mem_addr[p], sel_d ? data_addr[p] : instr_addr[p]);
      chk("rnd_mem_wr", mem_wr[p], sel_d ? data_wr[p] : 1'b0);
      chk("rnd_mem_byteen", mem_byteen[p], sel_d ? data_byteen[p] : {BW{1'b1}});
      if (sel_d) chk("rnd_mem_wdata", mem_wdata[p], data_wdata[p]);
    end
    chk("rnd_instr_valid", instr_valid[p], e_iv);
    chk("rnd_data_valid", data_valid[p], e_dv);
    chk("rnd_instr_rdata", instr_rdata[p], e_iv ? mem_rdata[p] : '0);
    chk("rnd_data_rdata", data_rdata[p], e_dv ? mem_rdata[p] : '0);
    chk("rnd_instr_err", instr_err[p], e_iv && mem_err[p]);
    chk("rnd_orphan", orphan_resp[p], m_orphan);

    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(sel_d);
      m_pref_data = !sel_d;
    end
    m_locked    = ereq && !mem_gnt[p];
    m_lock_data = sel_d;
    if (mem_valid[p] && sz == 0) m_orphan = 1'b1;
  endtask

  // Protocol-respecting random traffic: a request stays up, unchanged, until
  // it is granted; responses come only for outstanding grants except for a
  // rare stray pulse.
  task automatic run_random(input int p, input int ncyc);
    bit i_hold, d_hold, e_igt, e_dgt;
    do_reset();
    model_reset();
    i_hold = 1'b0;
    d_hold = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!i_hold) begin
        instr_req[p]  = ($urandom_range(0, 2) != 0);
        instr_addr[p] = $urandom() & 32'h0000_fffc;
      end
      if (!d_hold) begin
        data_req[p]    = ($urandom_range(0, 2) != 0);
        data_wr[p]     = $urandom_range(0, 1) != 0;
        data_addr[p]   = $urandom();
        data_wdata[p]  = $urandom();
        data_byteen[p] = BW'($urandom_range(0, 15));
      end
      mem_gnt[p]   = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0) mem_valid[p] = ($urandom_range(0, 1) != 0);
      else                mem_valid[p] = ($urandom_range(0, 63) == 0);
      mem_rdata[p] = $urandom();
      mem_err[p]   = ($urandom_range(0, 3) == 0);
      #1;
      model_cycle(p, e_igt, e_dgt);
      i_hold = instr_req[p] && !e_igt;
      d_hold = data_req[p] && !e_dgt;
      @(negedge clk);
    end
    idle_all();
  endtask

  // ---------------------------------------------------------------------------
  // Single-cycle vector table (each applied from a fresh reset)
  // ---------------------------------------------------------------------------
  typedef struct {
    int          p;
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    bit          dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    bit          mgnt;
    bit          e_req;
    bit          e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    bit          e_igt;
    bit          e_dgt;
    bit          e_dsel;
  } vec_t;

  function automatic vec_t mk(int p, bit ireq, logic [31:0] iaddr, bit dreq, bit dwr,
                              logic [31:0] daddr, logic [31:0] dwdata, logic [3:0] dbe,
                              bit mgnt, bit e_req, bit e_wr, logic [31:0] e_addr,
                              logic [3:0] e_be, bit e_igt, bit e_dgt, bit e_dsel);
    vec_t v;
    v.p = p; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr;
    v.daddr = daddr; v.dwdata = dwdata; v.dbe = dbe; v.mgnt = mgnt;
    v.e_req = e_req; v.e_wr = e_wr; v.e_addr = e_addr; v.e_be = e_be;
    v.e_igt = e_igt; v.e_dgt = e_dgt; v.e_dsel = e_dsel;
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    idle_all();

    // ---- reset state: outputs quiet even with inputs active during reset
    @(negedge clk);
    reset = 1'b1;
    instr_req[0] = 1'b1; data_req[0] = 1'b1; mem_gnt[0] = 1'b1; mem_valid[0] = 1'b1;
    mem_rdata[0] = 32'h1234_5678;
    #1;
    chk("rst_mem_req", mem_req[0], 1'b0);
    chk("rst_instr_gnt", instr_gnt[0], 1'b0);
    chk("rst_data_gnt", data_gnt[0], 1'b0);
    chk("rst_instr_valid", instr_valid[0], 1'b0);
    chk("rst_data_valid", data_valid[0], 1'b0);
    chk("rst_data_rdata", data_rdata[0], 32'h0);
    @(negedge clk);
    chk("rst_orphan", orphan_resp[0], 1'b0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    idle_all();
    reset = 1'b0;

    // ---- table vectors
    vecs[0] = mk(0, 1, 32'h0,  0, 0, 32'h0,   32'h0,         4'h0, 1, 1, 0, 32'h0,   4'hf, 1, 0, 0);
    vecs[1] = mk(0, 1, 32'h10, 1, 1, 32'h200, 32'h1234_5678, 4'h3, 1, 1, 1, 32'h200, 4'h3, 0, 1, 1);
    vecs[2] = mk(0, 0, 32'h0,  1, 0, 32'h204, 32'h0,         4'hc, 0, 1, 0, 32'h204, 4'hc, 0, 0, 1);
    vecs[3] = mk(0, 0, 32'h8,  0, 0, 32'h0,   32'h0,         4'h0, 1, 0, 0, 32'h0,   4'h0, 0, 0, 0);
    vecs[4] = mk(1, 1, 32'h10, 1, 1, 32'h200, 32'h0,         4'hf, 1, 1, 0, 32'h10,  4'hf, 1, 0, 0);
    vecs[5] = mk(1, 0, 32'h0,  1, 1, 32'h208, 32'hdead_beef, 4'h5, 1, 1, 1, 32'h208, 4'h5, 0, 1, 1);
    vecs[6] = mk(1, 1, 32'h20, 1, 0, 32'h300, 32'h0,         4'hf, 0, 1, 0, 32'h20,  4'hf, 0, 0, 0);
    vecs[7] = mk(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,         4'h0, 0, 1, 0, 32'h44,  4'hf, 0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      int p;
      do_reset();
      p = vecs[v].p;
      instr_req[p]   = vecs[v].ireq;
      instr_addr[p]  = vecs[v].iaddr;
      data_req[p]    = vecs[v].dreq;
      data_wr[p]     = vecs[v].dwr;
      data_addr[p]   = vecs[v].daddr;
      data_wdata[p]  = vecs[v].dwdata;
      data_byteen[p] = vecs[v].dbe;
      mem_gnt[p]     = vecs[v].mgnt;
      #1;
      chk($sformatf("vec%0d_mem_req", v), mem_req[p], vecs[v].e_req);
      chk($sformatf("vec%0d_instr_gnt", v), instr_gnt[p], vecs[v].e_igt);
      chk($sformatf("vec%0d_data_gnt", v), data_gnt[p], vecs[v].e_dgt);
      if (vecs[v].e_req) begin
        chk($sformatf("vec%0d_mem_addr", v), mem_addr[p], vecs[v].e_addr);
        chk($sformatf("vec%0d_mem_wr", v), mem_wr[p], vecs[v].e_wr);
        chk($sformatf("vec%0d_mem_byteen", v), mem_byteen[p], vecs[v].e_be);
        if (vecs[v].e_dsel) chk($sformatf("vec%0d_mem_wdata", v), mem_wdata[p], vecs[v].dwdata);
      end
      idle_all();
    end

    // ---- seq A: three instruction fetches, responses one cycle later
    do_reset();
    instr_req[0] = 1'b1; instr_addr[0] = 32'h0; mem_gnt[0] = 1'b1;
    #1; chk("a0_igt", instr_gnt[0], 1'b1); chk("a0_addr", mem_addr[0], 32'h0);
    @(negedge clk);
    instr_addr[0] = 32'h4; mem_valid[0] = 1'b1; mem_rdata[0] = 32'ha000_0000;
    #1; chk("a1_igt", instr_gnt[0], 1'b1); chk("a1_addr", mem_addr[0], 32'h4);
    chk("a1_ivalid", instr_valid[0], 1'b1); chk("a1_irdata", instr_rdata[0], 32'ha000_0000);
    chk("a1_dvalid", data_valid[0], 1'b0);
    @(negedge clk);
    instr_addr[0] = 32'h8; mem_rdata[0] = 32'ha000_0001;
    #1; chk("a2_igt", instr_gnt[0], 1'b1); chk("a2_addr", mem_addr[0], 32'h8);
    chk("a2_ivalid", instr_valid[0], 1'b1); chk("a2_irdata", instr_rdata[0], 32'ha000_0001);
    chk("a2_dvalid", data_valid[0], 1'b0);
    @(negedge clk);
    instr_req[0] = 1'b0; mem_rdata[0] = 32'ha000_0002;
    #1; chk("a3_ivalid", instr_valid[0], 1'b1); chk("a3_irdata", instr_rdata[0], 32'ha000_0002);
    chk("a3_dvalid", data_valid[0], 1'b0); chk("a3_mem_req", mem_req[0], 1'b0);
    @(negedge clk);
    mem_valid[0] = 1'b0;
    #1; chk("a4_ivalid", instr_valid[0], 1'b0); chk("a4_irdata", instr_rdata[0], 32'h0);

    // ---- seq B: fixed priority, data first, responses routed D then I
    do_reset();
    instr_req[0] = 1'b1; instr_addr[0] = 32'h10;
    data_req[0] = 1'b1; data_addr[0] = 32'h200; mem_gnt[0] = 1'b1;
    #1; chk("b0_dgt", data_gnt[0], 1'b1); chk("b0_igt", instr_gnt[0], 1'b0);
    chk("b0_addr", mem_addr[0], 32'h200);
    @(negedge clk);
    data_req[0] = 1'b0; mem_valid[0] = 1'b1; mem_rdata[0] = 32'hd0d0_d0d0; mem_err[0] = 1'b1;
    #1; chk("b1_igt", instr_gnt[0], 1'b1); chk("b1_addr", mem_addr[0], 32'h10);
    chk("b1_dvalid", data_valid[0], 1'b1); chk("b1_drdata", data_rdata[0], 32'hd0d0_d0d0);
    chk("b1_ivalid", instr_valid[0], 1'b0); chk("b1_ierr", instr_err[0], 1'b0);
    @(negedge clk);
    instr_req[0] = 1'b0; mem_rdata[0] = 32'h1111_2222;
    #1; chk("b2_ivalid", instr_valid[0], 1'b1); chk("b2_irdata", instr_rdata[0], 32'h1111_2222);
    chk("b2_ierr", instr_err[0], 1'b1); chk("b2_dvalid", data_valid[0], 1'b0);
    chk("b2_drdata", data_rdata[0], 32'h0);

    // ---- seq C: round-robin alternation I,D,I,D with in-order routing
    do_reset();
    instr_req[1] = 1'b1; instr_addr[1] = 32'h40;
    data_req[1] = 1'b1; data_addr[1] = 32'h80; mem_gnt[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_valid[1] = (k > 0);
      mem_rdata[1] = 32'hc000_0000 + k;
      #1;
      chk($sformatf("c%0d_igt", k), instr_gnt[1], (k % 2) == 0);
      chk($sformatf("c%0d_dgt", k), data_gnt[1], (k % 2) == 1);
      chk($sformatf("c%0d_ivalid", k), instr_valid[1], (k % 2) == 1);
      chk($sformatf("c%0d_dvalid", k), data_valid[1], k == 2);
      @(negedge clk);
    end
    idle_all();

    // ---- seq D: outstanding limit, pop does not bypass
    do_reset();
    instr_req[0] = 1'b1; instr_addr[0] = 32'h100; mem_gnt[0] = 1'b1;
    #1; chk("d0_igt", instr_gnt[0], 1'b1);
    @(negedge clk);
    #1; chk("d1_igt", instr_gnt[0], 1'b1);
    @(negedge clk);
    #1; chk("d2_mem_req", mem_req[0], 1'b0); chk("d2_igt", instr_gnt[0], 1'b0);
    @(negedge clk);
    mem_valid[0] = 1'b1; mem_rdata[0] = 32'h55;
    #1; chk("d3_mem_req", mem_req[0], 1'b0); chk("d3_ivalid", instr_valid[0], 1'b1);
    @(negedge clk);
    mem_valid[0] = 1'b0;
    #1; chk("d4_mem_req", mem_req[0], 1'b1); chk("d4_igt", instr_gnt[0], 1'b1);

    // ---- seq E: lock holds instr selection while data_req rises
    do_reset();
    instr_req[0] = 1'b1; instr_addr[0] = 32'h40; mem_gnt[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("e%0d_addr", k), mem_addr[0], 32'h40);
      chk($sformatf("e%0d_igt", k), instr_gnt[0], 1'b0);
      @(negedge clk);
    end
    data_req[0] = 1'b1; data_wr[0] = 1'b1; data_addr[0] = 32'h300;
    data_wdata[0] = 32'hcafe; data_byteen[0] = 4'hf;
    #1; chk("e3_addr", mem_addr[0], 32'h40); chk("e3_wr", mem_wr[0], 1'b0);
    chk("e3_dgt", data_gnt[0], 1'b0);
    @(negedge clk);
    mem_gnt[0] = 1'b1;
    #1; chk("e4_igt", instr_gnt[0], 1'b1); chk("e4_dgt", data_gnt[0], 1'b0);
    chk("e4_addr", mem_addr[0], 32'h40);
    @(negedge clk);
    instr_req[0] = 1'b0;
    #1; chk("e5_dgt", data_gnt[0], 1'b1); chk("e5_addr", mem_addr[0], 32'h300);
    chk("e5_wr", mem_wr[0], 1'b1); chk("e5_wdata", mem_wdata[0], 32'hcafe);

    // ---- seq F: reset drops outstanding, responses become orphans
    do_reset();
    instr_req[0] = 1'b1; mem_gnt[0] = 1'b1;
    #1; chk("f0_igt", instr_gnt[0], 1'b1);
    @(negedge clk);
    #1; chk("f1_igt", instr_gnt[0], 1'b1);
    @(negedge clk);
    reset = 1'b1; idle_all();
    #1; chk("f2_mem_req", mem_req[0], 1'b0);
    @(negedge clk);
    reset = 1'b0; mem_valid[0] = 1'b1; mem_rdata[0] = 32'hbad0;
    #1; chk("f3_ivalid", instr_valid[0], 1'b0); chk("f3_orphan", orphan_resp[0], 1'b0);
    chk("f3_irdata", instr_rdata[0], 32'h0);
    @(negedge clk);
    #1; chk("f4_ivalid", instr_valid[0], 1'b0); chk("f4_dvalid", data_valid[0], 1'b0);
    chk("f4_orphan", orphan_resp[0], 1'b1);
    @(negedge clk);
    mem_valid[0] = 1'b0;
    #1; chk("f5_orphan", orphan_resp[0], 1'b1);
    do_reset();
    #1; chk("f6_orphan", orphan_resp[0], 1'b0);

    // ---- randomized traffic against the reference model
    run_random(0, 400);
    run_random(1, 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the test is fixed-length, this only guards against a stall.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
